matmul_sequencer: RTL

Host-side sequencer for the 2x2 systolic matrix-multiply array. It accepts eight operand bytes over a valid/ready byte stream and presents them as parallel A/B operands. It then pulses the array's start input, waits for the array's done, and captures the four result bytes. Finally it streams the results back out over a second valid/ready byte stream. The block sits between the host/IO fabric and the array.

---
 rtl/matmul_sequencer.sv | 90 +++++++++
 1 files changed

// File: rtl/matmul_sequencer.sv
// matmul_sequencer: loads 2x2 A/B operands from a byte stream, runs the systolic array, streams results back
module matmul_sequencer #(
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] A00,
    output logic [7:0] A01,
    output logic [7:0] A10,
    output logic [7:0] A11,
    output logic [7:0] B00,
    output logic [7:0] B01,
    output logic [7:0] B10,
    output logic [7:0] B11,
    output logic       start,
    input  logic [7:0] C00,
    input  logic [7:0] C01,
    input  logic [7:0] C10,
    input  logic [7:0] C11,
    input  logic       done,
    output logic       busy,
    output logic       err
);
    typedef enum logic [1:0] {LOAD, START, WAIT, DRAIN} state_t;
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
    state_t          state;
    logic [2:0]      ld_idx;
    logic [1:0]      dr_idx;
    logic [7:0]      cnt;
    logic [7:0][7:0] ops;
    logic [3:0][7:0] res;
    logic            in_fire;
    logic            out_fire;
    assign in_ready  = state == LOAD;
    assign out_valid = state == DRAIN;
    assign busy      = state != LOAD;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign out_data  = res[dr_idx];
    assign {B11, B10, B01, B00, A11, A10, A01, A00} = ops;
    // sequencer: operand load, start pulse, wait-for-done with timeout, result drain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= LOAD;
            ld_idx <= '0;
            dr_idx <= '0;
            cnt    <= '0;
            ops    <= '0;
            res    <= '0;
            start  <= 1'b0;
            err    <= 1'b0;
        end else begin
            start <= 1'b0;
            case (state)
                LOAD: if (in_fire) begin
                    ops[ld_idx] <= in_data;
                    ld_idx      <= ld_idx + 3'd1;
                    if (ld_idx == 3'd0) err <= 1'b0;
                    if (ld_idx == 3'd7) begin
                        state <= START;
                        start <= 1'b1;
                    end
                end
                START: begin
                    state <= WAIT;
                    cnt   <= '0;
                end
                WAIT: begin
                    cnt <= cnt + 8'd1;
                    if (done || cnt == TO_LAST) begin
                        res   <= {C11, C10, C01, C00};
                        state <= DRAIN;
                        if (!done) err <= 1'b1;
                    end
                end
                DRAIN: if (out_fire) begin
                    dr_idx <= dr_idx + 2'd1;
                    if (dr_idx == 2'd3) state <= LOAD;
                end
                default: state <= LOAD;
            endcase
        end
    end
endmodule
